music_box_state_make_recording: RTL and testbench
=================================================

Name: music_box_state_make_recording

Overview:
- User-interface state module, active while mainState equals STATE_ID.
- Captures one 8-bit audio sample per sample_tick into a small FIFO.
- Drains the FIFO into SDRAM as write commands over the shared SDRAM command interface, at sequential addresses from BASE_ADDR.
- Writer counterpart of the playback state: it fills the recording region that playback reads back.

Parameters:
- STATE_ID, 5'd2: mainState value that enables this module.
- SAMPLE_COUNT, 110250: samples to record (5 s at 22050 Hz); range 1 to 2^19-1.
- FIFO_DEPTH, 8: sample FIFO entries; power of two, 2 to 16.
- BASE_ADDR, 25'd0: first SDRAM word address.

Ports:
- clock_50Mhz  in  1  system clock; all logic on posedge.
- reset_n  in  1  reset; synchronous, active-low.
- mainState  in  5  top-level state from the state controller.
- sample_tick  in  1  one-cycle strobe at 22050 Hz, synchronous to clock_50Mhz.
- audio_sample  in  8  unsigned sample, valid when sample_tick=1.
- stateComplete  out  1  recording finished (success or fail); held until exit.
- recordFailed  out  1  FIFO overflow occurred; valid when stateComplete=1.
- debugString  out  32  [31:29] FSM code, [28:25] FIFO level, [24:0] current write address.
- sdram_inputAddress  out  25  command word address.
- sdram_writeData  out  16  write data.
- sdram_isWriting  out  1  1 = write; driven 1 whenever sdram_inputValid=1.
- sdram_inputValid  out  1  command request.
- sdram_recievedCommand  in  1  controller accepted the held command.
- sdram_isBusy  in  1  controller busy; no new command may be raised.

Behaviour:
- Reset and exit:
  - reset_n=0, or mainState!=STATE_ID, at a clock edge clears everything at that edge.
  - All outputs go to 0; FIFO, address, and sample counters are cleared; FSM goes to IDLE.
  - This applies mid-operation: a pending command is abandoned and sdram_inputValid is 0 after that edge.
- FSM codes: IDLE=0, RUN=1, DRAIN=2, DONE=3, FAIL=4.
  - IDLE -> RUN one cycle after mainState==STATE_ID is first seen.
  - RUN: each sample_tick pushes audio_sample and increments the taken count. After SAMPLE_COUNT samples are taken, go to DRAIN; later ticks are ignored.
  - DRAIN -> DONE when the FIFO is empty and no command is pending.
  - DONE: stateComplete=1, recordFailed=0.
  - FAIL: stateComplete=1, recordFailed=1, sdram_inputValid=0, FIFO contents discarded.
  - DONE and FAIL are held until exit or reset.
- sample_tick is ignored in IDLE, DRAIN, DONE and FAIL.
- Overflow: a sample_tick with the FIFO full and no pop in the same cycle moves the FSM to FAIL at that edge. A push and pop in the same cycle while full is legal; the level is unchanged.
- SDRAM write handshake:
  - Issue a command only when all of these hold: FIFO has a complete word, no command is pending, sdram_isBusy=0, and the FSM is in RUN or DRAIN.
  - Issue sets sdram_inputValid=1, sdram_isWriting=1, sdram_inputAddress=current address, sdram_writeData=word, all registered.
  - Address, data and valid stay stable until sdram_recievedCommand=1 is sampled. The command may be held indefinitely.
  - On the accept edge: sdram_inputValid goes to 0, the word is popped, and the address increments by 1 (25-bit, wraps).
  - At least one idle cycle (valid=0) separates commands.
  - sdram_isBusy going high while valid=1 does not withdraw the held command.
- Word format (default): {8'h00, sample}, one sample per address. Writes total SAMPLE_COUNT, at addresses BASE_ADDR to BASE_ADDR+SAMPLE_COUNT-1.
- Sample counter is 19 bits; the FIFO level counter is log2(FIFO_DEPTH)+1 bits.

Optional Feature:
- Macro: MUSICBOX_RECORD_PACK_EN.
- Defined:
  - Two samples per word: first in [7:0], second in [15:8].
  - A word becomes eligible once both halves are present.
  - If SAMPLE_COUNT is odd, the final word is {8'h80, last} and becomes eligible on entering DRAIN.
  - Writes total ceil(SAMPLE_COUNT/2).
- Undefined: default one-sample-per-word format; no packing logic is present.

Test Plan:
- SAMPLE_COUNT=4, ticks carrying 0x10,0x20,0x30,0x40, responder accepts 2 cycles after valid -> writes {addr 0: 0x0010}, {1: 0x0020}, {2: 0x0030}, {3: 0x0040}; then stateComplete=1, recordFailed=0, sdram_inputValid=0.
- sdram_recievedCommand withheld 50 cycles on the first command -> sdram_inputAddress=0, sdram_writeData=0x0010 and sdram_inputValid=1 stable all 50 cycles; exactly one accept is recorded.
- FIFO_DEPTH=8, sdram_isBusy=1 continuously, 9 ticks -> first 8 accepted; the 9th tick gives FSM code 4, stateComplete=1, recordFailed=1, no write ever issued.
- After 2 accepted writes, mainState changes -> next edge all outputs 0. Re-enter STATE_ID -> first write goes to BASE_ADDR again.
- MUSICBOX_RECORD_PACK_EN defined, SAMPLE_COUNT=3, samples 0x11,0x22,0x33 -> writes {0: 0x2211}, {1: 0x8033}, then DONE.
- reset_n=0 for one cycle while sdram_inputValid=1 -> next edge sdram_inputValid=0, stateComplete=0, debugString=0.

Source files
------------

// File: rtl/music_box_state_make_recording.sv
// Recording state of the music box: buffers audio samples in a FIFO and streams them to SDRAM.
// Define MUSICBOX_RECORD_PACK_EN to pack two samples into each 16-bit SDRAM word.
module music_box_state_make_recording #(
    parameter logic [4:0]  STATE_ID     = 5'd2,
    parameter int unsigned SAMPLE_COUNT = 110250,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter logic [24:0] BASE_ADDR    = 25'd0
) (
    input  logic        clock_50Mhz,
    input  logic        reset_n,
    input  logic [4:0]  mainState,
    input  logic        sample_tick,
    input  logic [7:0]  audio_sample,
    output logic        stateComplete,
    output logic        recordFailed,
    output logic [31:0] debugString,
    output logic [24:0] sdram_inputAddress,
    output logic [15:0] sdram_writeData,
    output logic        sdram_isWriting,
    output logic        sdram_inputValid,
    input  logic        sdram_recievedCommand,
    input  logic        sdram_isBusy
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned CNT_W = 19;
    localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'(SAMPLE_COUNT - 1);
    localparam logic [LVL_W-1:0] FULL_LEVEL  = LVL_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        DRAIN = 3'd2,
        DONE  = 3'd3,
        FAIL  = 3'd4
    } state_t;

    state_t           state;
    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level;
    logic [CNT_W-1:0] taken;
    logic [24:0]      addr;

    logic             active_c;
    logic             accept_c;
    logic             full_c;
    logic             tick_c;
    logic             overflow_c;
    logic             push_c;
    logic             word_ready_c;
    logic             issue_c;
    logic [LVL_W-1:0] pop_cnt_c;
    logic [15:0]      word_c;

    assign active_c   = reset_n && (mainState == STATE_ID);
    assign accept_c   = sdram_inputValid && sdram_recievedCommand;
    assign full_c     = (level == FULL_LEVEL);
    assign tick_c     = (state == RUN) && sample_tick;
    assign overflow_c = tick_c && full_c && !accept_c;
    assign push_c     = active_c && tick_c && !overflow_c;

`ifdef MUSICBOX_RECORD_PACK_EN
    logic pend_two;
    logic two_ready_c;

    // A lone trailing sample only becomes a word once no more samples can arrive.
    assign two_ready_c  = (level >= LVL_W'(2));
    assign word_ready_c = two_ready_c || ((state == DRAIN) && (level == LVL_W'(1)));
    assign word_c       = two_ready_c ? {fifo_mem[PTR_W'(rd_ptr + 1'b1)], fifo_mem[rd_ptr]}
                                      : {8'h80, fifo_mem[rd_ptr]};
    assign pop_cnt_c    = !accept_c ? '0 : (pend_two ? LVL_W'(2) : LVL_W'(1));
`else
    assign word_ready_c = (level != '0);
    assign word_c       = {8'h00, fifo_mem[rd_ptr]};
    assign pop_cnt_c    = LVL_W'(accept_c);
`endif

    assign issue_c = active_c && ((state == RUN) || (state == DRAIN)) && !sdram_inputValid
                     && word_ready_c && !sdram_isBusy && !overflow_c;

    assign debugString = {state, 4'(level), addr};

    // Sample storage; pointers and level carry all the control state.
    always_ff @(posedge clock_50Mhz) begin
        if (push_c) begin
            fifo_mem[wr_ptr] <= audio_sample;
        end
    end

    always_ff @(posedge clock_50Mhz) begin
        if (!active_c) begin
            state              <= IDLE;
            wr_ptr             <= '0;
            rd_ptr             <= '0;
            level              <= '0;
            taken              <= '0;
            addr               <= '0;
            stateComplete      <= 1'b0;
            recordFailed       <= 1'b0;
            sdram_inputAddress <= '0;
            sdram_writeData    <= '0;
            sdram_isWriting    <= 1'b0;
            sdram_inputValid   <= 1'b0;
`ifdef MUSICBOX_RECORD_PACK_EN
            pend_two           <= 1'b0;
`endif
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + 1'b1;
                taken  <= taken + 1'b1;
            end
            level <= level + LVL_W'(push_c) - pop_cnt_c;

            if (accept_c) begin
                rd_ptr           <= rd_ptr + PTR_W'(pop_cnt_c);
                addr             <= addr + 25'd1;
                sdram_inputValid <= 1'b0;
                sdram_isWriting  <= 1'b0;
            end

            if (issue_c) begin
                sdram_inputValid   <= 1'b1;
                sdram_isWriting    <= 1'b1;
                sdram_inputAddress <= addr;
                sdram_writeData    <= word_c;
`ifdef MUSICBOX_RECORD_PACK_EN
                pend_two           <= two_ready_c;
`endif
            end

            case (state)
                IDLE: begin
                    state <= RUN;
                    addr  <= BASE_ADDR;
                end
                RUN: begin
                    if (push_c && (taken == LAST_SAMPLE)) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if ((level == '0) && !sdram_inputValid) begin
                        state         <= DONE;
                        stateComplete <= 1'b1;
                    end
                end
                DONE, FAIL: begin
                end
                default: state <= IDLE;
            endcase

            // Overflow abandons the recording: drop the pending command and flush the FIFO.
            if (overflow_c) begin
                state            <= FAIL;
                stateComplete    <= 1'b1;
                recordFailed     <= 1'b1;
                sdram_inputValid <= 1'b0;
                sdram_isWriting  <= 1'b0;
                level            <= '0;
                wr_ptr           <= '0;
                rd_ptr           <= '0;
            end
        end
    end
endmodule

// File: tb/tb_music_box_state_make_recording.sv
// Directed bench for the recording state: normal run, held command, exit/re-entry, reset, overflow.
module tb_music_box_state_make_recording;
    logic        clk;
    logic        reset_n;
    logic        tick;
    logic [7:0]  sample;

    logic [4:0]  ms_a, ms_b;
    logic        busy_a, recv_a, busy_b, recv_b;
    logic        done_a, failed_a, wr_a, valid_a;
    logic        done_b, failed_b, wr_b, valid_b;
    logic [31:0] dbg_a, dbg_b;
    logic [24:0] addr_a, addr_b;
    logic [15:0] wdata_a, wdata_b;

    int checks = 0;
    int failures = 0;
    logic seen_valid_b = 1'b0;

    music_box_state_make_recording #(
        .STATE_ID(5'd2), .SAMPLE_COUNT(4), .FIFO_DEPTH(8), .BASE_ADDR(25'd0)
    ) dut_a (
        .clock_50Mhz(clk), .reset_n(reset_n), .mainState(ms_a),
        .sample_tick(tick), .audio_sample(sample),
        .stateComplete(done_a), .recordFailed(failed_a), .debugString(dbg_a),
        .sdram_inputAddress(addr_a), .sdram_writeData(wdata_a),
        .sdram_isWriting(wr_a), .sdram_inputValid(valid_a),
        .sdram_recievedCommand(recv_a), .sdram_isBusy(busy_a)
    );

    music_box_state_make_recording #(
        .STATE_ID(5'd2), .SAMPLE_COUNT(16), .FIFO_DEPTH(8), .BASE_ADDR(25'd0)
    ) dut_b (
        .clock_50Mhz(clk), .reset_n(reset_n), .mainState(ms_b),
        .sample_tick(tick), .audio_sample(sample),
        .stateComplete(done_b), .recordFailed(failed_b), .debugString(dbg_b),
        .sdram_inputAddress(addr_b), .sdram_writeData(wdata_b),
        .sdram_isWriting(wr_b), .sdram_inputValid(valid_b),
        .sdram_recievedCommand(recv_b), .sdram_isBusy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (valid_b === 1'b1) seen_valid_b <= 1'b1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid_a(input string tag);
        int n = 0;
        while (valid_a !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check(tag, 32'(valid_a), 32'd1);
    endtask

    task automatic accept_a();
        recv_a = 1'b1;
        step();
        recv_a = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; tick = 1'b0; sample = 8'h00;
        ms_a = 5'd0; ms_b = 5'd0;
        busy_a = 1'b0; recv_a = 1'b0; busy_b = 1'b0; recv_b = 1'b0;
        repeat (3) step();

        check("rst_complete", 32'(done_a), 32'd0);
        check("rst_failed",   32'(failed_a), 32'd0);
        check("rst_debug",    dbg_a, 32'd0);
        check("rst_valid",    32'(valid_a), 32'd0);
        check("rst_addr",     32'(addr_a), 32'd0);
        check("rst_wdata",    32'(wdata_a), 32'd0);

        // Session 1: four samples, each command accepted two cycles after it is raised.
        reset_n = 1'b1;
        ms_a = 5'd2;
        step();
        check("s1_run_code", 32'(dbg_a[31:29]), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            tick = 1'b1; sample = 8'(i * 16);
            step();
        end
        tick = 1'b0;
        check("s1_drain_debug", dbg_a, 32'h4800_0000);
        for (int i = 0; i < 4; i++) begin
            wait_valid_a("s1_wait_valid");
            check("s1_addr",    32'(addr_a), 32'(i));
            check("s1_wdata",   32'(wdata_a), 32'((i + 1) * 16));
            check("s1_writing", 32'(wr_a), 32'd1);
            step();
            step();
            check("s1_still_valid", 32'(valid_a), 32'd1);
            accept_a();
            check("s1_valid_drop", 32'(valid_a), 32'd0);
        end
        step();
        check("s1_done_complete", 32'(done_a), 32'd1);
        check("s1_done_failed",   32'(failed_a), 32'd0);
        check("s1_done_debug",    dbg_a, 32'h6000_0004);
        repeat (5) step();
        check("s1_done_held",  32'(done_a), 32'd1);
        check("s1_done_valid", 32'(valid_a), 32'd0);

        // Exit clears everything on the next edge.
        ms_a = 5'd0;
        step();
        check("exit_complete", 32'(done_a), 32'd0);
        check("exit_debug",    dbg_a, 32'd0);

        // Session 2: first command held for 50 cycles, then two accepts, then exit mid-command.
        ms_a = 5'd2;
        step();
        tick = 1'b1; sample = 8'hA1; step();
        sample = 8'hA2; step();
        sample = 8'hA3; step();
        tick = 1'b0;
        begin
            int n_stable = 0;
            for (int k = 0; k < 50; k++) begin
                if (valid_a === 1'b1 && addr_a === 25'd0 && wdata_a === 16'h00A1) n_stable++;
                step();
            end
            check("hold_stable_cycles", 32'(n_stable), 32'd50);
        end
        accept_a();
        check("hold_valid_drop", 32'(valid_a), 32'd0);
        wait_valid_a("s2_wait_valid2");
        check("s2_addr2",  32'(addr_a), 32'd1);
        check("s2_wdata2", 32'(wdata_a), 32'h00A2);
        accept_a();
        step();
        check("s2_third_valid", 32'(valid_a), 32'd1);
        check("s2_third_addr",  32'(addr_a), 32'd2);
        ms_a = 5'd5;
        step();
        check("s2_exit_valid",   32'(valid_a), 32'd0);
        check("s2_exit_writing", 32'(wr_a), 32'd0);
        check("s2_exit_addr",    32'(addr_a), 32'd0);
        check("s2_exit_wdata",   32'(wdata_a), 32'd0);
        check("s2_exit_debug",   dbg_a, 32'd0);
        check("s2_exit_done",    32'(done_a), 32'd0);

        // Re-entry restarts at the base address.
        ms_a = 5'd2;
        step();
        tick = 1'b1; sample = 8'hB1; step();
        tick = 1'b0;
        wait_valid_a("s3_wait_valid");
        check("s3_addr",  32'(addr_a), 32'd0);
        check("s3_wdata", 32'(wdata_a), 32'h00B1);

        // One-cycle reset while a command is pending.
        reset_n = 1'b0;
        step();
        check("rst_mid_valid", 32'(valid_a), 32'd0);
        check("rst_mid_done",  32'(done_a), 32'd0);
        check("rst_mid_debug", dbg_a, 32'd0);
        reset_n = 1'b1;
        ms_a = 5'd0;
        step();

        // Overflow: controller permanently busy, nine back-to-back samples into an 8-deep FIFO.
        busy_b = 1'b1;
        ms_b = 5'd2;
        step();
        for (int i = 0; i < 8; i++) begin
            tick = 1'b1; sample = 8'(i);
            step();
        end
        check("ovf_full_debug", dbg_b, 32'h3000_0000);
        check("ovf_full_done",  32'(done_b), 32'd0);
        sample = 8'hFF;
        step();
        tick = 1'b0;
        check("ovf_fail_debug",  dbg_b, 32'h8000_0000);
        check("ovf_fail_done",   32'(done_b), 32'd1);
        check("ovf_fail_failed", 32'(failed_b), 32'd1);
        check("ovf_fail_valid",  32'(valid_b), 32'd0);
        busy_b = 1'b0;
        tick = 1'b1; sample = 8'h55;
        repeat (4) step();
        tick = 1'b0;
        check("ovf_fail_held",  32'(done_b), 32'd1);
        check("ovf_fail_code",  32'(dbg_b[31:29]), 32'd4);
        check("ovf_never_wrote", 32'(seen_valid_b), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
